// File: rtl/branch_resolver.sv
// Branch resolver: FIFO of predicted branches, resolved in execute; a mispredict redirects fetch,
// restores the PSW and holds a flush. Optional stats counters with BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int DEPTH        = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef BRANCH_RESOLVER_STATS_EN
    output logic [15:0]              branch_cnt,
    output logic [15:0]              mispredict_cnt,
`endif
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic                     push_pred_taken,
    input  logic [3:0]               push_cond,
    input  logic [PC_W-1:0]          push_target,
    input  logic [PC_W-1:0]          push_fall,
    input  logic [PC_W-1:0]          push_psw,
    input  logic                     ex_valid,
    input  logic [PC_W-1:0]          ex_psw,
    output logic                     redirect_valid,
    output logic [PC_W-1:0]          redirect_pc,
    output logic                     psw_restore_valid,
    output logic [PC_W-1:0]          psw_restore,
    output logic                     flush,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     proto_err,
    output logic [1:0]               o_dbg_state
);
    // Handshake: a record transfers on a rising clk edge where push_valid & push_ready are both 1;
    // push_ready depends only on registered state/occupancy, never on push_valid or ex_valid.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {S_RST = 2'd0, S_IDLE = 2'd1, S_FLUSH = 2'd2} state_t;

    state_t            r_state, w_state_nxt;
    logic [FC_W-1:0]   r_flush_cnt, w_flush_cnt_nxt;
    logic [PC_W-1:0]   r_tgt  [DEPTH];
    logic [PC_W-1:0]   r_fall [DEPTH];
    logic [PC_W-1:0]   r_psw  [DEPTH];
    logic [3:0]        r_cond [DEPTH];
    logic              r_pred [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_occ;
    logic              w_ready, w_empty, w_actual;
    logic              w_push, w_pop, w_mispredict, w_proto_set;
    logic [3:0]        w_h_cond;

    assign w_empty     = (r_occ == '0);
    assign w_ready     = (r_occ < CNT_W'(DEPTH)) && (r_state == S_IDLE);
    assign push_ready  = w_ready;
    assign occupancy   = r_occ;
    assign o_dbg_state = r_state;
    assign w_h_cond    = r_cond[r_rd_ptr];

    // XM23 condition evaluation on live flags: C=0, Z=1, N=2, V=4.
    always_comb begin
        w_actual = 1'b1;
        if (!w_h_cond[3]) begin
            unique case (w_h_cond[2:0])
                3'd0: w_actual = ex_psw[1];
                3'd1: w_actual = !ex_psw[1];
                3'd2: w_actual = ex_psw[0];
                3'd3: w_actual = !ex_psw[0];
                3'd4: w_actual = ex_psw[2];
                3'd5: w_actual = !(ex_psw[2] ^ ex_psw[4]);
                3'd6: w_actual = ex_psw[2] ^ ex_psw[4];
                default: w_actual = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_mispredict    = 1'b0;
        w_proto_set     = 1'b0;
        unique case (r_state)
            S_RST: begin
                w_state_nxt = S_IDLE;
                w_proto_set = ex_valid;
            end
            S_IDLE: begin
                w_push = push_valid && w_ready;
                if (ex_valid) begin
                    if (w_empty) begin
                        w_proto_set = 1'b1;
                    end else begin
                        w_pop = 1'b1;
                        if (w_actual != r_pred[r_rd_ptr]) begin
                            // Wrong path: a same-cycle push belongs to it and is dropped.
                            w_mispredict    = 1'b1;
                            w_push          = 1'b0;
                            w_state_nxt     = S_FLUSH;
                            w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == '0) w_state_nxt = S_IDLE;
                else                   w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RST;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_occ             <= '0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
            psw_restore_valid <= 1'b0;
            psw_restore       <= '0;
            flush             <= 1'b0;
            proto_err         <= 1'b0;
        end else begin
            redirect_valid    <= w_mispredict;
            psw_restore_valid <= w_mispredict;
            flush             <= (w_state_nxt == S_FLUSH);
            proto_err         <= proto_err | w_proto_set;
            if (w_mispredict) begin
                redirect_pc <= w_actual ? r_tgt[r_rd_ptr] : r_fall[r_rd_ptr];
                psw_restore <= r_psw[r_rd_ptr];
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_occ       <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_occ <= r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tgt[r_wr_ptr]  <= push_target;
            r_fall[r_wr_ptr] <= push_fall;
            r_psw[r_wr_ptr]  <= push_psw;
            r_cond[r_wr_ptr] <= push_cond;
            r_pred[r_wr_ptr] <= push_pred_taken;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (w_pop && branch_cnt != 16'hFFFF)           branch_cnt     <= branch_cnt + 16'd1;
            if (w_mispredict && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios plus randomized traffic against a queue-based model.
module tb_branch_resolver;
    localparam int DEPTH = 2;
    localparam int FLUSH = 2;

    typedef struct packed {
        logic        pred;
        logic [3:0]  cond;
        logic [15:0] target;
        logic [15:0] fall;
        logic [15:0] psw;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_valid, push_ready, push_pred_taken;
    logic [3:0]  push_cond;
    logic [15:0] push_target, push_fall, push_psw;
    logic        ex_valid;
    logic [15:0] ex_psw;
    logic        redirect_valid, psw_restore_valid, flush, proto_err;
    logic [15:0] redirect_pc, psw_restore;
    logic [1:0]  occupancy;
    logic [1:0]  dbg_state;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] branch_cnt, mispredict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    rec_t        m_q[$];
    int          m_left;
    bit          m_boot;
    bit          m_rv, m_flush, m_proto;
    logic [15:0] m_rpc, m_rpsw;
    int          m_branch, m_misp;

    branch_resolver dut (
        .clk(clk), .rst_n(rst_n),
`ifdef BRANCH_RESOLVER_STATS_EN
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt),
`endif
        .push_valid(push_valid), .push_ready(push_ready), .push_pred_taken(push_pred_taken),
        .push_cond(push_cond), .push_target(push_target), .push_fall(push_fall), .push_psw(push_psw),
        .ex_valid(ex_valid), .ex_psw(ex_psw),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .psw_restore_valid(psw_restore_valid), .psw_restore(psw_restore),
        .flush(flush), .occupancy(occupancy), .proto_err(proto_err), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic bit ref_taken(input logic [3:0] cond, input logic [15:0] psw);
        bit c, z, n, v;
        c = psw[0]; z = psw[1]; n = psw[2]; v = psw[4];
        if (cond[3]) return 1'b1;
        case (cond[2:0])
            3'd0: return z;
            3'd1: return !z;
            3'd2: return c;
            3'd3: return !c;
            3'd4: return n;
            3'd5: return n == v;
            3'd6: return n != v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit model_ready();
        return !m_boot && m_left == 0 && m_q.size() < DEPTH;
    endfunction

    task automatic model_step(input bit pv, input rec_t r, input bit ev, input logic [15:0] psw);
        bit   rdy, act, do_push;
        rec_t h;
        rdy  = model_ready();
        m_rv = 1'b0;
        if (rst_n !== 1'b1) begin
            m_q.delete(); m_left = 0; m_boot = 1; m_flush = 0; m_proto = 0;
            m_branch = 0; m_misp = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_flush = (m_left > 0);
        end else if (m_boot) begin
            m_boot = 0;
            if (ev) m_proto = 1;
        end else begin
            m_flush = 0;
            do_push = pv && rdy;
            if (ev) begin
                if (m_q.size() == 0) begin
                    m_proto = 1;
                end else begin
                    h   = m_q.pop_front();
                    act = ref_taken(h.cond, psw);
                    if (m_branch < 65535) m_branch++;
                    if (act != h.pred) begin
                        m_rv = 1; m_rpc = act ? h.target : h.fall; m_rpsw = h.psw;
                        m_flush = 1; m_left = FLUSH; do_push = 0;
                        m_q.delete();
                        if (m_misp < 65535) m_misp++;
                    end
                end
            end
            if (do_push) m_q.push_back(r);
        end
    endtask

    task automatic tick(input bit pv, input rec_t r, input bit ev, input logic [15:0] psw);
        push_valid = pv; push_pred_taken = r.pred; push_cond = r.cond;
        push_target = r.target; push_fall = r.fall; push_psw = r.psw;
        ex_valid = ev; ex_psw = psw;
        model_step(pv, r, ev, psw);
        @(posedge clk);
        @(negedge clk);
        push_valid = 1'b0; ex_valid = 1'b0;
    endtask

    function automatic rec_t mk(input bit pred, input logic [3:0] cond, input logic [15:0] t,
                                input logic [15:0] f, input logic [15:0] p);
        rec_t r;
        r.pred = pred; r.cond = cond; r.target = t; r.fall = f; r.psw = p;
        return r;
    endfunction

    task automatic test_reset();
        rec_t z;
        z = mk(0, 4'd0, 16'h0, 16'h0, 16'h0);
        rst_n = 1'b0;
        tick(0, z, 0, 16'h0);
        tick(0, z, 0, 16'h0);
        n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL rst_redirect got=%b exp=0", redirect_valid); end
        n_cmp++; if (psw_restore_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pswv got=%b exp=0", psw_restore_valid); end
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush got=%b exp=0", flush); end
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL rst_proto got=%b exp=0", proto_err); end
        n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", push_ready); end
        rst_n = 1'b1;
        tick(0, z, 0, 16'h0);
        n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got=%b exp=1", push_ready); end
    endtask

    task automatic test_match();
        rec_t r;
        r = mk(1, 4'b0000, 16'h0100, 16'h0042, 16'h1234);
        tick(1, r, 0, 16'h0);
        n_cmp++; if (occupancy !== 2'd1) begin n_bad++; $display("FAIL match_occ1 got=%0d exp=1", occupancy); end
        tick(0, r, 1, 16'h0002);
        n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL match_redirect got=%b exp=0", redirect_valid); end
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL match_flush got=%b exp=0", flush); end
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL match_occ0 got=%0d exp=0", occupancy); end
    endtask

    task automatic test_mispredict();
        rec_t r;
        r = mk(1, 4'b0000, 16'h0100, 16'h0042, 16'hABCD);
        tick(1, r, 0, 16'h0);
        tick(0, r, 1, 16'h0000);
        n_cmp++; if (redirect_valid !== 1'b1) begin n_bad++; $display("FAIL misp_rv got=%b exp=1", redirect_valid); end
        n_cmp++; if (redirect_pc !== 16'h0042) begin n_bad++; $display("FAIL misp_pc got=%h exp=0042", redirect_pc); end
        n_cmp++; if (psw_restore_valid !== 1'b1) begin n_bad++; $display("FAIL misp_pswv got=%b exp=1", psw_restore_valid); end
        n_cmp++; if (psw_restore !== 16'hABCD) begin n_bad++; $display("FAIL misp_psw got=%h exp=abcd", psw_restore); end
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL misp_flush1 got=%b exp=1", flush); end
        tick(0, r, 0, 16'h0);
        n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL misp_rv_pulse got=%b exp=0", redirect_valid); end
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL misp_flush2 got=%b exp=1", flush); end
        tick(0, r, 0, 16'h0);
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL misp_flush3 got=%b exp=0", flush); end
        n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL misp_ready got=%b exp=1", push_ready); end
    endtask

    task automatic test_full_flush();
        rec_t r1, r2, r3;
        r1 = mk(1, 4'b0000, 16'h0300, 16'h0302, 16'h0011);
        r2 = mk(0, 4'b1000, 16'h0400, 16'h0402, 16'h0022);
        r3 = mk(0, 4'b0010, 16'h0500, 16'h0502, 16'h0033);
        tick(1, r1, 0, 16'h0);
        tick(1, r2, 0, 16'h0);
        n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL full_occ got=%0d exp=2", occupancy); end
        n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b exp=0", push_ready); end
        tick(1, r3, 1, 16'h0000);
        n_cmp++; if (redirect_pc !== 16'h0302) begin n_bad++; $display("FAIL full_pc got=%h exp=0302", redirect_pc); end
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL full_occ0 got=%0d exp=0", occupancy); end
        tick(1, r3, 1, 16'h0000);
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL flush_push_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL flush_ex_ignored got=%b exp=0", proto_err); end
        tick(1, r3, 0, 16'h0);
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL flush_push2_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL full_flush_end got=%b exp=0", flush); end
    endtask

    task automatic test_cond101();
        rec_t r;
        r = mk(0, 4'b0101, 16'h0200, 16'h0044, 16'h0055);
        tick(1, r, 0, 16'h0);
        tick(0, r, 1, 16'h0004);
        n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL c101_nv10_rv got=%b exp=0", redirect_valid); end
        tick(1, r, 0, 16'h0);
        tick(0, r, 1, 16'h0014);
        n_cmp++; if (redirect_valid !== 1'b1) begin n_bad++; $display("FAIL c101_nv11_rv got=%b exp=1", redirect_valid); end
        n_cmp++; if (redirect_pc !== 16'h0200) begin n_bad++; $display("FAIL c101_pc got=%h exp=0200", redirect_pc); end
        tick(0, r, 0, 16'h0);
        tick(0, r, 0, 16'h0);
    endtask

    task automatic test_random();
        rec_t r;
        bit   pv, ev;
        logic [15:0] psw;
        for (int i = 0; i < 600; i++) begin
            r   = mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)),
                     16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            pv  = 1'($urandom_range(0, 1));
            ev  = ($urandom_range(0, 2) == 0);
            psw = 16'($urandom_range(0, 65535));
            tick(pv, r, ev, psw);
            n_cmp++; if (redirect_valid !== m_rv) begin n_bad++; $display("FAIL rnd_rv i=%0d got=%b exp=%b", i, redirect_valid, m_rv); end
            n_cmp++; if (psw_restore_valid !== m_rv) begin n_bad++; $display("FAIL rnd_pswv i=%0d got=%b exp=%b", i, psw_restore_valid, m_rv); end
            n_cmp++; if (flush !== m_flush) begin n_bad++; $display("FAIL rnd_flush i=%0d got=%b exp=%b", i, flush, m_flush); end
            n_cmp++; if (occupancy !== 2'(m_q.size())) begin n_bad++; $display("FAIL rnd_occ i=%0d got=%0d exp=%0d", i, occupancy, m_q.size()); end
            n_cmp++; if (proto_err !== m_proto) begin n_bad++; $display("FAIL rnd_proto i=%0d got=%b exp=%b", i, proto_err, m_proto); end
            n_cmp++; if (push_ready !== model_ready()) begin n_bad++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, push_ready, model_ready()); end
            if (m_rv) begin
                n_cmp++; if (redirect_pc !== m_rpc) begin n_bad++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, redirect_pc, m_rpc); end
                n_cmp++; if (psw_restore !== m_rpsw) begin n_bad++; $display("FAIL rnd_psw i=%0d got=%h exp=%h", i, psw_restore, m_rpsw); end
            end
        end
`ifdef BRANCH_RESOLVER_STATS_EN
        n_cmp++; if (branch_cnt !== 16'(m_branch)) begin n_bad++; $display("FAIL stats_branch got=%0d exp=%0d", branch_cnt, m_branch); end
        n_cmp++; if (mispredict_cnt !== 16'(m_misp)) begin n_bad++; $display("FAIL stats_misp got=%0d exp=%0d", mispredict_cnt, m_misp); end
`endif
        rst_n = 1'b0;
        tick(0, r, 0, 16'h0);
        rst_n = 1'b1;
        tick(0, r, 0, 16'h0);
    endtask

    task automatic test_empty_pop();
        rec_t r;
        r = mk(0, 4'd0, 16'h0, 16'h0, 16'h0);
        tick(0, r, 1, 16'h0);
        n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL empty_proto got=%b exp=1", proto_err); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL empty_rv got=%b exp=0", redirect_valid); end
        tick(0, r, 0, 16'h0);
        n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL empty_sticky got=%b exp=1", proto_err); end
        rst_n = 1'b0;
        tick(0, r, 0, 16'h0);
        n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL empty_rst_clear got=%b exp=0", proto_err); end
        rst_n = 1'b1;
        tick(0, r, 0, 16'h0);
    endtask

    task automatic test_reset_mid_flush();
        rec_t r;
        r = mk(1, 4'b0000, 16'h0600, 16'h0602, 16'h0077);
        tick(1, r, 0, 16'h0);
        tick(0, r, 1, 16'h0000);
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL rmf_flush1 got=%b exp=1", flush); end
        rst_n = 1'b0;
        tick(0, r, 0, 16'h0);
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rmf_flush got=%b exp=0", flush); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL rmf_rv got=%b exp=0", redirect_valid); end
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL rmf_occ got=%0d exp=0", occupancy); end
`ifdef BRANCH_RESOLVER_STATS_EN
        n_cmp++; if (branch_cnt !== 16'd0) begin n_bad++; $display("FAIL rmf_stats got=%0d exp=0", branch_cnt); end
`endif
        rst_n = 1'b1;
        tick(0, r, 0, 16'h0);
        tick(0, r, 0, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0; push_valid = 1'b0; ex_valid = 1'b0; push_pred_taken = 1'b0;
        push_cond = '0; push_target = '0; push_fall = '0; push_psw = '0; ex_psw = '0;
        m_left = 0; m_boot = 1; m_rv = 0; m_flush = 0; m_proto = 0; m_rpc = '0; m_rpsw = '0;
        m_branch = 0; m_misp = 0;
        @(negedge clk);
        test_reset();
        test_match();
        test_mispredict();
        test_full_flush();
        test_cond101();
        test_random();
        test_empty_pop();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
